// File: rtl/tree_reduce_accumulator.sv
// Pipelined adder-tree reduction of NUM_IN lanes per beat with multi-beat
// accumulation, lane masking, saturation/overflow flag and ready/valid flow.
// Ports: clk, rst_n (async, active-low)
//   in_valid/in_ready/in_data/in_mask/in_last   : beat input handshake
//   out_valid/out_ready/out_sum/out_beats/out_overflow : packet result
module tree_reduce_accumulator #(
  parameter int NUM_IN    = 64,
  parameter int IN_W      = 16,
  parameter int OUT_W     = 24,
  parameter bit SIGNED_IN = 1'b1,
  parameter bit SATURATE  = 1'b1,
  parameter int BEAT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic [NUM_IN-1:0]      in_mask,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_sum,
  output logic [BEAT_W-1:0]      out_beats,
  output logic                   out_overflow
);

  localparam int LOG2N = $clog2(NUM_IN);
  localparam int TW    = IN_W + LOG2N;
  localparam int NODES = 2 * NUM_IN - 1;

  // Tree nodes live in one flat array, level l starting at off(l).
  function automatic int off(input int l);
    return 2 * NUM_IN - 2 * (NUM_IN >> l);
  endfunction

  function automatic logic [TW-1:0] ext_lane(
    input logic [IN_W-1:0] x
  );
    if (SIGNED_IN)
      return {{LOG2N{x[IN_W-1]}}, x};
    return {{LOG2N{1'b0}}, x};
  endfunction

  logic [TW-1:0]     node [NODES];
  logic [LOG2N:0]    tv;
  logic [LOG2N:0]    tl;
  logic              stall;
  logic              take;

  logic [OUT_W-1:0]  acc;
  logic [BEAT_W-1:0] beats;
  logic              ovf;
  logic              first;
  logic              done;

  logic [OUT_W-1:0]  op;
  logic [OUT_W:0]    s;
  logic              over;
  logic [OUT_W-1:0]  sat;
  logic [OUT_W-1:0]  nacc;
  logic [BEAT_W-1:0] nbeats;
  logic              novf;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++)
        node[i] <= '0;
      tv <= '0;
      tl <= '0;
    end else if (!stall) begin
      tv <= {tv[LOG2N-1:0], take};
      tl <= {tl[LOG2N-1:0], take && in_last};
      for (int k = 0; k < NUM_IN; k++)
        node[k] <= in_mask[k] ?
          ext_lane(in_data[k*IN_W +: IN_W]) : '0;
      for (int l = 1; l <= LOG2N; l++)
        for (int k = 0; k < (NUM_IN >> l); k++)
          node[off(l)+k] <= node[off(l-1)+2*k]
                          + node[off(l-1)+2*k+1];
    end
  end

  always_comb begin
    op     = '0;
    s      = '0;
    over   = 1'b0;
    sat    = '0;
    nacc   = '0;
    nbeats = '0;
    novf   = 1'b0;
    if (SIGNED_IN) begin
      op   = OUT_W'($signed(node[NODES-1]));
      s    = {op[OUT_W-1], op} + {acc[OUT_W-1], acc};
      // Signed overflow: the extra sign bit disagrees with the MSB.
      over = s[OUT_W] != s[OUT_W-1];
      sat  = s[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                      : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      op   = OUT_W'(node[NODES-1]);
      s    = {1'b0, op} + {1'b0, acc};
      over = s[OUT_W];
      sat  = '1;
    end
    if (first) begin
      nacc   = op;
      nbeats = BEAT_W'(1);
      novf   = 1'b0;
    end else begin
      nacc   = (over && SATURATE) ? sat : s[OUT_W-1:0];
      nbeats = (&beats) ? beats : beats + BEAT_W'(1);
      novf   = ovf | over;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      beats        <= '0;
      ovf          <= 1'b0;
      first        <= 1'b1;
      done         <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_beats    <= '0;
      out_overflow <= 1'b0;
    end else if (!stall) begin
      done <= tv[LOG2N] && tl[LOG2N];
      if (tv[LOG2N]) begin
        acc   <= nacc;
        beats <= nbeats;
        ovf   <= novf;
        first <= tl[LOG2N];
      end
      out_valid <= done;
      if (done) begin
        out_sum      <= acc;
        out_beats    <= beats;
        out_overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_tree_reduce_accumulator.sv
// Directed bench for tree_reduce_accumulator: default, unsigned and
// wrapping instances driven in lockstep from shared inputs.
module tb_tree_reduce_accumulator;

  localparam int N  = 64;
  localparam int W  = 16;
  localparam int OW = 24;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]  in_mask = '1;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;

  logic          rdy_d, rdy_u, rdy_w;
  logic          vld_d, vld_u, vld_w;
  logic [OW-1:0] sum_d, sum_u, sum_w;
  logic [BW-1:0] bt_d, bt_u, bt_w;
  logic          ov_d, ov_u, ov_w;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [OW-1:0] sd, su, sw;
    logic [BW-1:0] b;
    logic          od, ou, ow;
  } res_t;
  res_t q[$];

  always #5 clk = ~clk;

  tree_reduce_accumulator u_def (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_d),
    .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
    .out_valid(vld_d), .out_ready(out_ready),
    .out_sum(sum_d), .out_beats(bt_d), .out_overflow(ov_d)
  );

  tree_reduce_accumulator #(.SIGNED_IN(1'b0)) u_uns (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_u),
    .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
    .out_valid(vld_u), .out_ready(out_ready),
    .out_sum(sum_u), .out_beats(bt_u), .out_overflow(ov_u)
  );

  tree_reduce_accumulator #(.SATURATE(1'b0)) u_wrp (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_w),
    .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
    .out_valid(vld_w), .out_ready(out_ready),
    .out_sum(sum_w), .out_beats(bt_w), .out_overflow(ov_w)
  );

  // Record every handshake of the default instance.
  always @(negedge clk) begin
    if (vld_d && out_ready) begin
      res_t r;
      r.sd = sum_d; r.su = sum_u; r.sw = sum_w;
      r.b  = bt_d;
      r.od = ov_d;  r.ou = ov_u;  r.ow = ov_w;
      q.push_back(r);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
    return {N{v}};
  endfunction

  task automatic send(input logic [N*W-1:0] d,
                      input logic [N-1:0] m,
                      input logic l);
    int n;
    in_data  = d;
    in_mask  = m;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    while (!rdy_d && n < 200) begin
      tick();
      n++;
    end
    if (!rdy_d) check("send_timeout", 32'(rdy_d), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input int cnt);
    int n;
    n = 0;
    while (q.size() < cnt && n < 100) begin
      tick();
      n++;
    end
    check("out_count", 32'(q.size()), 32'(cnt));
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!vld_d && n < 100) begin
      tick();
      n++;
    end
    check("wait_valid", 32'(vld_d), 32'd1);
  endtask

  logic [N*W-1:0] d;

  initial begin
    tick();
    check("rst_valid", 32'(vld_d), 32'd0);
    check("rst_sum", 32'(sum_d), 32'd0);
    check("rst_beats", 32'(bt_d), 32'd0);
    check("rst_ovf", 32'(ov_d), 32'd0);
    check("rst_ready", 32'(rdy_d), 32'd1);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(rdy_d), 32'd1);

    // Single beat, latency
    q.delete();
    send(fill(16'h0100), '1, 1'b1);
    repeat (7) tick();
    check("lat_t7", 32'(vld_d), 32'd0);
    tick();
    check("lat_t8", 32'(vld_d), 32'd1);
    check("one_sum", 32'(sum_d), 32'h004000);
    check("one_beats", 32'(bt_d), 32'd1);
    check("one_ovf", 32'(ov_d), 32'd0);
    tick();
    check("lat_t9", 32'(vld_d), 32'd0);
    check("one_cnt", 32'(q.size()), 32'd1);

    // All ones: signed vs unsigned
    q.delete();
    send(fill(16'hFFFF), '1, 1'b1);
    wait_out(1);
    if (q.size() >= 1) begin
      check("neg_signed", 32'(q[0].sd), 32'hFFFFC0);
      check("neg_unsigned", 32'(q[0].su), 32'h3FFFC0);
    end

    // Masking
    q.delete();
    for (int k = 0; k < N; k++)
      d[k*W +: W] = (k < 10) ? 16'h0005 : 16'h7FFF;
    send(d, 64'h3FF, 1'b1);
    wait_out(1);
    if (q.size() >= 1) begin
      check("mask_sum", 32'(q[0].sd), 32'd50);
      check("mask_sum_u", 32'(q[0].su), 32'd50);
    end

    // Three beats
    q.delete();
    for (int i = 0; i < 3; i++)
      send(fill(16'h7FFF), '1, i == 2);
    wait_out(1);
    if (q.size() >= 1) begin
      check("b3_sum", 32'(q[0].sd), 32'h5FFF40);
      check("b3_beats", 32'(q[0].b), 32'd3);
      check("b3_ovf", 32'(q[0].od), 32'd0);
    end

    // Five beats: positive overflow
    q.delete();
    for (int i = 0; i < 5; i++)
      send(fill(16'h7FFF), '1, i == 4);
    wait_out(1);
    if (q.size() >= 1) begin
      check("b5_sat", 32'(q[0].sd), 32'h7FFFFF);
      check("b5_sat_ovf", 32'(q[0].od), 32'd1);
      check("b5_wrap", 32'(q[0].sw), 32'h9FFEC0);
      check("b5_wrap_ovf", 32'(q[0].ow), 32'd1);
      check("b5_uns", 32'(q[0].su), 32'h9FFEC0);
      check("b5_uns_ovf", 32'(q[0].ou), 32'd0);
      check("b5_beats", 32'(q[0].b), 32'd5);
    end

    // Five beats: negative overflow
    q.delete();
    for (int i = 0; i < 5; i++)
      send(fill(16'h8000), '1, i == 4);
    wait_out(1);
    if (q.size() >= 1) begin
      check("neg_sat", 32'(q[0].sd), 32'h800000);
      check("neg_sat_ovf", 32'(q[0].od), 32'd1);
      check("neg_wrap", 32'(q[0].sw), 32'h600000);
      check("neg_wrap_ovf", 32'(q[0].ow), 32'd1);
      check("neg_uns", 32'(q[0].su), 32'hA00000);
    end

    // Beat counter saturation
    q.delete();
    for (int i = 0; i < 300; i++)
      send(fill(16'h0000), '1, i == 299);
    wait_out(1);
    if (q.size() >= 1) begin
      check("sat_beats", 32'(q[0].b), 32'd255);
      check("sat_beats_sum", 32'(q[0].sd), 32'd0);
    end

    // Backpressure
    q.delete();
    out_ready = 1'b0;
    send(fill(16'h0001), '1, 1'b1);
    send(fill(16'h0002), '1, 1'b1);
    wait_valid();
    repeat (5) tick();
    check("bp_valid", 32'(vld_d), 32'd1);
    check("bp_hold", 32'(sum_d), 32'd64);
    check("bp_ready", 32'(rdy_d), 32'd0);
    out_ready = 1'b1;
    wait_out(2);
    repeat (12) tick();
    check("bp_cnt", 32'(q.size()), 32'd2);
    if (q.size() >= 2) begin
      check("bp_first", 32'(q[0].sd), 32'd64);
      check("bp_second", 32'(q[1].sd), 32'd128);
    end

    // Reset mid-packet and mid-stall
    q.delete();
    out_ready = 1'b0;
    send(fill(16'h0007), '1, 1'b1);
    send(fill(16'h0001), '1, 1'b0);
    send(fill(16'h0001), '1, 1'b0);
    wait_valid();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(vld_d), 32'd0);
    check("mid_rst_ready", 32'(rdy_d), 32'd1);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    q.delete();
    send(fill(16'h0001), '1, 1'b1);
    wait_out(1);
    if (q.size() >= 1) begin
      check("post_rst_sum", 32'(q[0].sd), 32'd64);
      check("post_rst_beats", 32'(q[0].b), 32'd1);
      check("post_rst_ovf", 32'(q[0].od), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tree_reduce_accumulator.md
Name: tree_reduce_accumulator

Overview:
Parametrised, pipelined adder-tree reduction with multi-beat accumulation and ready/valid flow control. Sums NUM_IN lanes per beat and accumulates successive beats until in_last, so softmax rows longer than NUM_IN are supported. Adds per-lane masking, a signed/unsigned mode, saturation with an overflow flag, and output backpressure. Sits between the exp stage and the reciprocal/normalise stage of the softmax datapath.

Parameters:
NUM_IN, 64, lanes per beat; power of 2, >=2; LOG2N = log2(NUM_IN)
IN_W, 16, lane width
OUT_W, 24, accumulator/output width; must be >= IN_W+LOG2N
SIGNED_IN, 1, 1 = lanes are two's complement (sign-extend); 0 = unsigned (zero-extend)
SATURATE, 1, 1 = clamp accumulator at OUT_W limits; 0 = wrap
BEAT_W, 8, width of beat counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
in_valid  in  1  beat present
in_ready  out  1  beat accepted when in_valid && in_ready
in_data  in  NUM_IN*IN_W  lane k at [k*IN_W +: IN_W]
in_mask  in  NUM_IN  1 = lane contributes; 0 = lane treated as 0
in_last  in  1  final beat of packet
out_valid  out  1  packet sum available
out_ready  in  1  consumer accepts when out_valid && out_ready
out_sum  out  OUT_W  packet sum (signedness per SIGNED_IN)
out_beats  out  BEAT_W  beats in packet, saturating at 2^BEAT_W-1
out_overflow  out  1  sticky: any accumulate in packet exceeded OUT_W range

Behaviour:
- Reset (async): out_valid=0, out_sum=0, out_beats=0, out_overflow=0, all stage valids/last bits=0, accumulator=0, first-beat flag=1. in_ready=1 after reset.
- Global stall: stall = out_valid && !out_ready; in_ready = !stall. Whole pipeline (all stages, accumulator, output) holds when stall=1. No skid buffer.
- Stage 0 (capture): on accepted beat register each lane, masked to 0 when in_mask[k]=0, extended to TW=IN_W+LOG2N bits; carry valid and last.
- Stages 1..LOG2N: pairwise adds (2k, 2k+1) at TW bits, one level per cycle; valid/last travel alongside. Idle stages carry valid=0 (bubbles allowed).
- Accumulate/output stage, on tree valid: operand = tree result extended to OUT_W per SIGNED_IN. If first-beat flag: acc=operand, beats=1, ovf=0; else acc=acc+operand evaluated at OUT_W+1 bits, beats+1 (saturating), ovf|=range exceeded. Out of range: SATURATE=1 clamps to max/min (signed: 0x7FF..F/0x800..0; unsigned: all-ones/0); SATURATE=0 wraps. Overflow flagged in both modes.
- When that beat has last=1: out_sum/out_beats/out_overflow load the final values, out_valid=1 next cycle, first-beat flag set for next packet. Otherwise first-beat flag cleared, no output.
- Latency: last beat accepted at edge t -> out_valid high after edge t+LOG2N+2 (8 cycles for NUM_IN=64), absent stalls. Throughput one beat/cycle.
- out_valid clears on handshake unless a new packet completes the same cycle, then outputs update and out_valid stays 1.
- Outputs stable while out_valid && !out_ready.
- Reset mid-packet or mid-stall: all partial state discarded; next beat after reset starts a fresh packet.
- in_last on every beat = one independent sum per beat (legacy single-row mode).

Test Plan:
- Defaults, one beat, all lanes 0x0100, mask all 1, last=1, out_ready=1 -> out_sum=0x004000, out_beats=1, overflow=0, out_valid 8 cycles after accept for 1 cycle.
- SIGNED_IN=1, all lanes 0xFFFF, last=1 -> out_sum=0xFFFFC0 (-64); rerun SIGNED_IN=0 -> out_sum=0x3FFFC0.
- Mask lanes 0..9 only, all lanes 0x0005 -> out_sum=50; lanes 10..63 set to 0x7FFF do not contribute.
- Three back-to-back beats all 0x7FFF, last on third -> out_sum=0x5FFF40, out_beats=3, overflow=0; then five beats -> out_sum=0x7FFFFF, overflow=1 (SATURATE=1); SATURATE=0 -> out_sum=0x9FFEC0 (wrapped), overflow=1.
- Back-to-back single-beat packets with values 1 and 2 per lane, out_ready=0 -> first sum 64 held stable, in_ready=0; release out_ready -> sums 64 then 128 delivered in order, none lost or duplicated.
- Assert rst_n low after beat 2 of a 4-beat packet -> out_valid=0 immediately; after release, single beat of 0x0001 lanes -> out_sum=64, out_beats=1.
